spi_flash_arbiter: RTL and testbench

Shares one SPI flash bus between two requesters. One is the JTAG-to-SPI bridge path (chip select, clock and data driven by the host through the user JTAG chain). The other is a fabric command engine that issues opcode / optional 24-bit address / read-data transactions.
Sits between the bridge outputs and the flash pins. When the JTAG path owns the bus, pins pass through unchanged. When the fabric owns it, the block generates mode-0 SCK itself.

---
 rtl/spi_flash_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - SPI flash bus arbiter between the JTAG bridge and a fabric command engine
module spi_flash_arbiter #(
  parameter int CLK_DIV   = 2,
  parameter int CSN_GUARD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jtag_csn,
  input  logic        jtag_sck,
  input  logic        jtag_sdi,
  output logic        jtag_sdo,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic        cmd_has_addr,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_rd_len,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        cmd_done,
  output logic        jtag_owner,
  output logic        flash_csn,
  output logic        flash_sck,
  output logic        flash_sdi,
  input  logic        flash_sdo
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CSN_GUARD > 1) ? $clog2(CSN_GUARD) : 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(CSN_GUARD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_JTAG  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          jcsn_s1_q, jcsn_s2_q;
  logic          owner_q, owner_d;
  logic          csn_q, csn_d;
  logic          sck_q, sck_d;
  logic [31:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic [11:0]   bit_q, bit_d;
  logic [11:0]   total_q, total_d;
  logic [5:0]    hdr_q, hdr_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          jreq;

  assign jreq = !jcsn_s2_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    csn_d      = csn_q;
    sck_d      = sck_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    bit_d      = bit_q;
    total_d    = total_q;
    hdr_d      = hdr_q;
    div_d      = div_q;
    guard_d    = guard_q;
    case (state_q)
      S_IDLE: begin
        if (jreq) begin
          state_d = S_JTAG;
          owner_d = 1'b1;
        end else if (cmd_valid) begin
          state_d = S_SHIFT;
          csn_d   = 1'b0;
          sck_d   = 1'b0;
          tx_d    = cmd_has_addr ? {cmd_opcode, cmd_addr} : {cmd_opcode, 24'h0};
          hdr_d   = cmd_has_addr ? 6'd32 : 6'd8;
          total_d = 12'(hdr_d) + {1'b0, cmd_rd_len, 3'b000};
          bit_d   = 12'd0;
          div_d   = '0;
        end
      end
      S_JTAG: begin
        if (!jreq) begin
          state_d = S_GUARD;
          owner_d = 1'b0;
          guard_d = '0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            // header bytes are whole bytes, so bit_q[2:0] also marks data byte ends
            if (bit_q >= {6'b0, hdr_q}) begin
              rx_d = {rx_q[6:0], flash_sdo};
              if (bit_q[2:0] == 3'd7) begin
                rd_valid_d = 1'b1;
                rd_data_d  = {rx_q[6:0], flash_sdo};
              end
            end
          end else begin
            sck_d = 1'b0;
            if (bit_q == total_q - 12'd1) begin
              state_d = S_GUARD;
              csn_d   = 1'b1;
              done_d  = 1'b1;
              guard_d = '0;
              tx_d    = 32'h0;
            end else begin
              bit_d = bit_q + 12'd1;
              tx_d  = {tx_q[30:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        if (guard_q == GUARD_MAX) state_d = S_IDLE;
        else                      guard_d = guard_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    jcsn_s1_q <= jtag_csn;
    jcsn_s2_q <= jcsn_s1_q;
    if (!rst_n) begin
      state_q    <= S_IDLE;
      jcsn_s1_q  <= 1'b1;
      jcsn_s2_q  <= 1'b1;
      owner_q    <= 1'b0;
      csn_q      <= 1'b1;
      sck_q      <= 1'b0;
      tx_q       <= 32'h0;
      rx_q       <= 8'h0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h0;
      done_q     <= 1'b0;
      bit_q      <= 12'd0;
      total_q    <= 12'd0;
      hdr_q      <= 6'd0;
      div_q      <= '0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      csn_q      <= csn_d;
      sck_q      <= sck_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      bit_q      <= bit_d;
      total_q    <= total_d;
      hdr_q      <= hdr_d;
      div_q      <= div_d;
      guard_q    <= guard_d;
    end
  end

  // JTAG ownership hands the raw bridge pins straight to the flash
  assign flash_csn  = owner_q ? jtag_csn : csn_q;
  assign flash_sck  = owner_q ? jtag_sck : sck_q;
  assign flash_sdi  = owner_q ? jtag_sdi : tx_q[31];
  assign jtag_sdo   = flash_sdo;
  assign jtag_owner = owner_q;
  assign cmd_ready  = rst_n && (state_q == S_IDLE) && !jreq;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign cmd_done   = done_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - randomized self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;
  localparam int CLK_DIV   = 2;
  localparam int CSN_GUARD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jtag_csn = 1'b1, jtag_sck = 1'b0, jtag_sdi = 1'b0, jtag_sdo;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_opcode = 8'h0;
  logic        cmd_has_addr = 1'b0;
  logic [23:0] cmd_addr = 24'h0;
  logic [7:0]  cmd_rd_len = 8'h0;
  logic        rd_valid, cmd_done, jtag_owner;
  logic [7:0]  rd_data;
  logic        flash_csn, flash_sck, flash_sdi;
  logic        flash_sdo = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] fixed_bytes[$];

  spi_flash_arbiter #(.CLK_DIV(CLK_DIV), .CSN_GUARD(CSN_GUARD)) dut (
    .clk(clk), .rst_n(rst_n),
    .jtag_csn(jtag_csn), .jtag_sck(jtag_sck), .jtag_sdi(jtag_sdi), .jtag_sdo(jtag_sdo),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr), .cmd_rd_len(cmd_rd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd_done(cmd_done), .jtag_owner(jtag_owner),
    .flash_csn(flash_csn), .flash_sck(flash_sck), .flash_sdi(flash_sdi), .flash_sdo(flash_sdo)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [7:0] op, input logic has, input logic [23:0] addr,
                         input logic [7:0] len);
    cmd_opcode = op; cmd_has_addr = has; cmd_addr = addr; cmd_rd_len = len; cmd_valid = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (!cmd_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
    expect_eq(tag, 32'(cmd_ready), 32'd1);
  endtask

  // Called at the negedge where cmd_valid&cmd_ready holds; acceptance happens on the next posedge.
  task automatic observe(input int stop_rises, input int jtag_drop_at, input bit exp_idle);
    int h, n, rise, fall, low, done;
    logic prev;
    logic resp[$];
    logic cap[$];
    logic [7:0] rb[$];
    logic [7:0] got[$];
    logic [31:0] got_hdr, exp_hdr;
    int tail_ones;
    h = cmd_has_addr ? 32 : 8;
    n = h + 8 * int'(cmd_rd_len);
    for (int i = 0; i < int'(cmd_rd_len); i++)
      rb.push_back(fixed_bytes.size() > 0 ? fixed_bytes.pop_front() : 8'($urandom));
    for (int i = 0; i < h; i++) resp.push_back(1'($urandom_range(0, 1)));
    foreach (rb[i]) for (int b = 7; b >= 0; b--) resp.push_back(rb[i][b]);
    exp_hdr = cmd_has_addr ? {cmd_opcode, cmd_addr} : {24'h0, cmd_opcode};
    flash_sdo = resp[0];
    rise = 0; fall = 0; low = 0; done = 0; prev = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (flash_sck && !prev) begin cap.push_back(flash_sdi); rise++; end
      if (!flash_sck && prev) begin fall++; if (fall < n) flash_sdo = resp[fall]; end
      prev = flash_sck;
      if (rd_valid) got.push_back(rd_data);
      if (!flash_csn) low++;
      if (jtag_drop_at > 0 && rise == jtag_drop_at) jtag_csn = 1'b0;
      if (cmd_done) begin done++; break; end
      if (stop_rises > 0 && rise >= stop_rises) return;
    end
    expect_eq("cmd_done_count", done, 1);
    expect_eq("sck_rises", rise, n);
    expect_eq("csn_low_cycles", low, 2 * n * CLK_DIV);
    got_hdr = 32'h0;
    for (int i = 0; i < h && i < cap.size(); i++) got_hdr = {got_hdr[30:0], cap[i]};
    expect_eq("header_bits", got_hdr, exp_hdr);
    tail_ones = 0;
    for (int i = h; i < cap.size(); i++) tail_ones += int'(cap[i]);
    expect_eq("tail_sdi_zero", tail_ones, 0);
    expect_eq("rd_count", got.size(), cmd_rd_len);
    foreach (rb[i]) expect_eq("rd_byte", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(rb[i]));
    expect_eq("guard_csn", 32'(flash_csn), 32'd1);
    expect_eq("guard_ready", 32'(cmd_ready), 32'd0);
    for (int g = 1; g < CSN_GUARD; g++) begin
      @(negedge clk);
      expect_eq("guard_csn", 32'(flash_csn), 32'd1);
      expect_eq("guard_sck", 32'(flash_sck), 32'd0);
      expect_eq("guard_no_done", 32'(cmd_done), 32'd0);
      expect_eq("guard_ready", 32'(cmd_ready), 32'd0);
    end
    if (exp_idle) begin
      @(negedge clk);
      expect_eq("ready_after_guard", 32'(cmd_ready), 32'd1);
    end
  endtask

  // Entered with jtag_csn low; checks pass-through, then release and guard back to a ready IDLE.
  task automatic jtag_session();
    int c;
    c = 0;
    while (!jtag_owner && c < 50) begin @(negedge clk); c++; end
    expect_eq("jtag_owner_rise", 32'(jtag_owner), 32'd1);
    for (int i = 0; i < 8; i++) begin
      jtag_sck = 1'($urandom); jtag_sdi = 1'($urandom); flash_sdo = 1'($urandom);
      #1;
      expect_eq("pt_sck", 32'(flash_sck), 32'(jtag_sck));
      expect_eq("pt_sdi", 32'(flash_sdi), 32'(jtag_sdi));
      expect_eq("pt_csn", 32'(flash_csn), 32'd0);
      expect_eq("pt_sdo", 32'(jtag_sdo), 32'(flash_sdo));
      expect_eq("pt_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    jtag_csn = 1'b1;
    #1;
    expect_eq("pt_csn_release", 32'(flash_csn), 32'd1);
    jtag_sck = 1'b0; jtag_sdi = 1'b0;
    c = 0;
    while (jtag_owner && c < 50) begin @(negedge clk); c++; end
    expect_eq("jtag_owner_fall", 32'(jtag_owner), 32'd0);
    c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
    expect_eq("jtag_to_ready", c, CSN_GUARD);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    expect_eq("rst_csn", 32'(flash_csn), 32'd1);
    expect_eq("rst_sck", 32'(flash_sck), 32'd0);
    expect_eq("rst_sdi", 32'(flash_sdi), 32'd0);
    expect_eq("rst_ready", 32'(cmd_ready), 32'd0);
    expect_eq("rst_strobes", {30'd0, rd_valid, cmd_done}, 32'd0);
    expect_eq("rst_rd_data", 32'(rd_data), 32'd0);
    expect_eq("rst_owner", 32'(jtag_owner), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_eq("idle_ready", 32'(cmd_ready), 32'd1);
    expect_eq("idle_csn", 32'(flash_csn), 32'd1);
    expect_eq("idle_sck", 32'(flash_sck), 32'd0);
    expect_eq("idle_owner", 32'(jtag_owner), 32'd0);

    // JEDEC ID read
    fixed_bytes = '{8'hEF, 8'h40, 8'h18};
    set_cmd(8'h9F, 1'b0, 24'h0, 8'd3);
    wait_ready("ready_9f");
    observe(0, 0, 1'b1);

    set_cmd(8'h03, 1'b1, 24'h123456, 8'd2);
    wait_ready("ready_03");
    observe(0, 0, 1'b1);

    // opcode-only command, shortest transaction
    set_cmd(8'h06, 1'b0, 24'h0, 8'd0);
    wait_ready("ready_06");
    observe(0, 0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      set_cmd(8'($urandom), 1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom_range(0, 4)));
      wait_ready("ready_rand");
      observe(0, 0, 1'b1);
    end

    // JTAG request arrives mid-transaction; held command waits for JTAG release plus guard
    set_cmd(8'h0B, 1'b1, 24'hABCDEF, 8'd2);
    wait_ready("ready_mid");
    observe(0, 20, 1'b0);
    set_cmd(8'h05, 1'b0, 24'h0, 8'd1);
    jtag_session();
    observe(0, 0, 1'b1);

    // JTAG and command contend in the same IDLE cycle
    jtag_csn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_cmd(8'h9F, 1'b0, 24'h0, 8'd1);
    #1;
    expect_eq("prio_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    expect_eq("prio_owner", 32'(jtag_owner), 32'd1);
    jtag_session();
    observe(0, 0, 1'b1);

    // reset during the address phase
    set_cmd(8'h03, 1'b1, 24'hFEDCBA, 8'd2);
    wait_ready("ready_rst");
    observe(14, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    expect_eq("abort_csn", 32'(flash_csn), 32'd1);
    expect_eq("abort_sck", 32'(flash_sck), 32'd0);
    expect_eq("abort_done", 32'(cmd_done), 32'd0);
    expect_eq("abort_owner", 32'(jtag_owner), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_eq("post_abort_no_done", 32'(cmd_done), 32'd0);
      expect_eq("post_abort_csn", 32'(flash_csn), 32'd1);
    end
    expect_eq("post_abort_ready", 32'(cmd_ready), 32'd1);
    set_cmd(8'h03, 1'b1, 24'h000100, 8'd3);
    wait_ready("ready_after_abort");
    observe(0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
